// File: rtl/ram_alu_seq.sv
// ram_alu_seq: command sequencer for the RAM-mapped ALU (X @0, Y @1, result @2).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready, in_x/y/op     command handshake and operands
//   alu_e/op/din/addr/w/r, alu_dout  ALU slot-access lines and result input
//   out_valid/out_ready, out_res     result handshake and captured result
//   out_err                          illegal-operand flag
//   done_cnt                         completed transactions (wraps)
// Optional: RAM_ALU_SEQ_ZGUARD_EN short-circuits illegal operands to DONE
// with out_res=0, out_err=1 and no ALU access.
module ram_alu_seq #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [1:0]        in_op,
    output logic              alu_e,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_din,
    output logic [1:0]        alu_addr,
    output logic              alu_w,
    output logic              alu_r,
    input  logic [RES_W-1:0]  alu_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_res,
    output logic              out_err,
    output logic [15:0]       done_cnt
);
    typedef enum logic [2:0] {IDLE, WR_X, WR_Y, RD, DONE} state_t;
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d, din_q, din_d;
    logic [1:0]        op_q, op_d, addr_q, addr_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [15:0]       done_q, done_d;
    logic              err_q, err_d, en_q, accept, zbad;

    assign accept = in_valid && in_ready;

`ifdef RAM_ALU_SEQ_ZGUARD_EN
    assign zbad = ((in_op == 2'd1 || in_op == 2'd2) && in_y == '0) || (in_op == 2'd3 && in_x == in_y);
`else
    assign zbad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            IDLE: if (accept) begin
                x_d     = in_x;
                y_d     = in_y;
                op_d    = in_op;
                err_d   = zbad;
                res_d   = zbad ? '0 : res_q;
                state_d = zbad ? DONE : WR_X;
            end
            WR_X: state_d = WR_Y;
            WR_Y: begin
                cnt_d   = '0;
                state_d = RD;
            end
            RD: if (cnt_q == CW'(RD_LAT - 1)) begin
                res_d   = alu_dout;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE: if (out_ready) begin
                done_d  = done_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // address/data registers are loaded for the state being entered so
        // they are valid during it, and hold once the sequence moves on
        addr_d = state_d == WR_X ? 2'd0 : state_d == WR_Y ? 2'd1 : state_d == RD ? 2'd2 : addr_q;
        din_d  = state_d == WR_X ? x_d : state_d == WR_Y ? y_q : din_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            en_q    <= 1'b1;
        end
    end

    // en_q is low only while in reset, gating in_ready and alu_e
    assign in_ready  = en_q && state_q == IDLE;
    assign alu_e     = en_q;
    assign alu_op    = op_q;
    assign alu_din   = din_q;
    assign alu_addr  = addr_q;
    assign alu_w     = state_q == WR_X || state_q == WR_Y;
    assign alu_r     = state_q == RD;
    assign out_valid = state_q == DONE;
    assign out_res   = res_q;
    assign out_err   = err_q;
    assign done_cnt  = done_q;
endmodule
